// File: rtl/imm_instr_encoder_pkg.sv
// Shared encodings, field widths and request payload for the RV32I instruction encoder.
package imm_instr_encoder_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMM_SRC_W = 3;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;

  // Immediate format selector, matching the decode-stage sign-extend unit.
  localparam logic [IMM_SRC_W-1:0] IMM_R  = 3'b000;
  localparam logic [IMM_SRC_W-1:0] IMM_U  = 3'b001;
  localparam logic [IMM_SRC_W-1:0] IMM_J  = 3'b010;
  localparam logic [IMM_SRC_W-1:0] IMM_B  = 3'b011;
  localparam logic [IMM_SRC_W-1:0] IMM_S  = 3'b100;
  localparam logic [IMM_SRC_W-1:0] IMM_I  = 3'b101;
  localparam logic [IMM_SRC_W-1:0] IMM_SH = 3'b110;

  // RV32I base opcodes.
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;

  // One encode request as captured by the first pipeline stage.
  typedef struct packed {
    logic [IMM_SRC_W-1:0] imm_src;
    logic [XLEN-1:0]      imm;
    logic [OPCODE_W-1:0]  opcode;
    logic [REG_W-1:0]     rd;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [FUNCT3_W-1:0]  funct3;
    logic [FUNCT7_W-1:0]  funct7;
  } enc_req_t;

  // True when v survives a round trip through a bits-wide signed field (v[31:bits-1] all equal).
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
    logic [XLEN-1:0] t;
    t = XLEN'($signed(v) >>> (bits - 1));
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_instr_encoder_pack_check.sv
// Combinational RV32I field packer with immediate range check.
module imm_pack_check
  import imm_instr_encoder_pkg::*;
(
  input  enc_req_t        i_req,
  output logic [XLEN-1:0] o_instr_c,
  output logic            o_err_c
);

  logic [XLEN-1:0] w_imm;
  assign w_imm = i_req.imm;

  // Pack fields per format; out-of-range immediates are packed from truncated bits.
  always_comb begin
    o_instr_c = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
    o_err_c   = 1'b0;
    case (i_req.imm_src)
      IMM_I: begin
        o_instr_c = {w_imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
        o_err_c   = !fits_signed(w_imm, 12);
      end
      IMM_SH: begin
        o_instr_c = {i_req.funct7, w_imm[4:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
        o_err_c   = |w_imm[31:5];
      end
      IMM_S: begin
        o_instr_c = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3, w_imm[4:0], i_req.opcode};
        o_err_c   = !fits_signed(w_imm, 12);
      end
      IMM_B: begin
        o_instr_c = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                     w_imm[4:1], w_imm[11], i_req.opcode};
        o_err_c   = !fits_signed(w_imm, 13) || w_imm[0];
      end
      IMM_U: begin
        o_instr_c = {w_imm[31:12], i_req.rd, i_req.opcode};
        o_err_c   = |w_imm[11:0];
      end
      IMM_J: begin
        o_instr_c = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_req.rd, i_req.opcode};
        o_err_c   = !fits_signed(w_imm, 21) || w_imm[0];
      end
      default: begin
        o_instr_c = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
        o_err_c   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with range check and error counter.
module imm_instr_encoder
  import imm_instr_encoder_pkg::*;
#(
  parameter bit          DROP_ON_ERR = 1'b0,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_SRC_W-1:0] ImmSrc,
  input  logic [XLEN-1:0]      Immediate_value,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_W-1:0]     rd,
  input  logic [REG_W-1:0]     rs1,
  input  logic [REG_W-1:0]     rs2,
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic [FUNCT7_W-1:0]  funct7,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      Instruction,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  enc_req_t             w_in_req;
  enc_req_t             r_s1_req;
  logic                 r_s1_valid;
  logic [XLEN-1:0]      w_s1_instr;
  logic                 w_s1_err;
  logic                 w_s1_drop;
  logic                 w_s1_advance;
  logic                 w_s1_leave;
  logic                 w_s2_load;
  logic                 r_s2_valid;
  logic [XLEN-1:0]      r_s2_instr;
  logic                 r_s2_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_in_req = '{imm_src: ImmSrc, imm: Immediate_value, opcode: opcode, rd: rd,
                      rs1: rs1, rs2: rs2, funct3: funct3, funct7: funct7};

  imm_pack_check u_pack_check (
    .i_req     (r_s1_req),
    .o_instr_c (w_s1_instr),
    .o_err_c   (w_s1_err)
  );

  // An erroneous entry may vanish from S1 regardless of S2 when dropping is enabled.
  assign w_s1_drop    = DROP_ON_ERR && w_s1_err;
  assign w_s1_advance = !r_s2_valid || out_ready || w_s1_drop;
  assign w_s1_leave   = r_s1_valid && w_s1_advance;
  assign w_s2_load    = w_s1_leave && !w_s1_drop;
  assign in_ready     = !r_s1_valid || w_s1_advance;

  // Stage 1: capture the request whenever the stage is free or moving on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_req   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_req <= w_in_req;
      end
    end
  end

  // Stage 2: hold the packed word while stalled, refill or empty when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s2_instr <= w_s1_instr;
      r_s2_err   <= w_s1_err;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Saturating count of erroneous entries leaving S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_s1_leave && w_s1_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign out_valid   = r_s2_valid;
  assign Instruction = r_s2_instr;
  assign out_err     = r_s2_err;
  assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed and randomized self-checking bench for imm_instr_encoder.
module tb_imm_instr_encoder;
  import imm_instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  imm_src;
  logic [31:0] imm;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_err0;
  logic [31:0] instr0;
  logic [7:0]  cnt0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [31:0] instr1;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  imm_instr_encoder #(.DROP_ON_ERR(1'b0), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .ImmSrc(imm_src), .Immediate_value(imm), .opcode(opc), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(f3), .funct7(f7), .out_valid(out_valid0), .out_ready(out_ready0),
    .Instruction(instr0), .out_err(out_err0), .err_count(cnt0)
  );

  imm_instr_encoder #(.DROP_ON_ERR(1'b1), .ERR_CNT_W(2)) dut_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .ImmSrc(imm_src), .Immediate_value(imm), .opcode(opc), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(f3), .funct7(f7), .out_valid(out_valid1), .out_ready(out_ready1),
    .Instruction(instr1), .out_err(out_err1), .err_count(cnt1)
  );

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic        err;
  } sb_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[17];
  vec_t bp[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] src, input logic [31:0] iv, input logic [6:0] op,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] fn3, input logic [6:0] fn7,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.src = src; v.imm = iv; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.f3 = fn3; v.f7 = fn7; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  // Decode-stage sign-extend unit: recovers the immediate from a packed word.
  function automatic logic [31:0] dec_imm(input logic [2:0] src, input logic [31:0] w);
    case (src)
      IMM_I:   return {{20{w[31]}}, w[31:20]};
      IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   return {w[31:12], 12'b0};
      IMM_J:   return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      IMM_SH:  return {27'b0, w[24:20]};
      default: return 32'b0;
    endcase
  endfunction

  // Representability expressed as numeric ranges of the immediate.
  function automatic logic exp_err(input logic [2:0] src, input logic [31:0] v);
    longint sv;
    sv = longint'($signed(v));
    case (src)
      IMM_I, IMM_S: return (sv < -2048) || (sv > 2047);
      IMM_B:        return (sv < -4096) || (sv > 4095) || v[0];
      IMM_J:        return (sv < -1048576) || (sv > 1048575) || v[0];
      IMM_U:        return (v % 32'd4096) != 32'd0;
      IMM_SH:       return v > 32'd31;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm();
    logic [31:0] b;
    logic [31:0] v;
    b = $urandom;
    case ($urandom_range(4))
      0:       v = b;
      1:       v = {{18{b[13]}}, b[13:0]};
      2:       v = {{10{b[21]}}, b[21:0]};
      3:       v = {26'b0, b[5:0]};
      default: v = {b[31:12], 12'b0};
    endcase
    if ($urandom_range(1) == 0) v[0] = 1'b0;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    imm_src = v.src; imm = v.imm; opc = v.op; rd = v.rd; rs1 = v.rs1;
    rs2 = v.rs2; f3 = v.f3; f7 = v.f7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Random traffic against one instance; scoreboard holds only words expected to emerge.
  task automatic run_random(input int sel, input int n);
    sb_t         q[$];
    sb_t         cur;
    sb_t         e;
    logic        have;
    logic        iv;
    logic        ov;
    logic        orr;
    logic        ir;
    logic [31:0] oi;
    logic        oe;
    logic [31:0] cnt;
    int          sent;
    int          nerr;
    int          cmax;
    have = 1'b0; sent = 0; nerr = 0;
    cmax = (sel == 1) ? 3 : 255;
    for (int cyc = 0; cyc < n * 8 + 200; cyc++) begin
      if (sent == n && q.size() == 0) break;
      if (!have && sent < n) begin
        cur.src = 3'($urandom_range(7));
        cur.imm = gen_imm();
        cur.op  = 7'($urandom);
        cur.err = exp_err(cur.src, cur.imm);
        imm_src = cur.src; imm = cur.imm; opc = cur.op;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        f3 = 3'($urandom); f7 = 7'($urandom);
        have = 1'b1;
      end
      iv  = have && ($urandom_range(3) != 0);
      orr = ($urandom_range(3) != 0);
      if (sel == 0) begin in_valid0 = iv; out_ready0 = orr; end
      else begin in_valid1 = iv; out_ready1 = orr; end
      #1;
      ov = (sel == 0) ? out_valid0 : out_valid1;
      ir = (sel == 0) ? in_ready0 : in_ready1;
      oi = (sel == 0) ? instr0 : instr1;
      oe = (sel == 0) ? out_err0 : out_err1;
      if (ov && orr) begin
        if (q.size() == 0) begin
          check("rnd_extra", 32'(ov), 32'd0);
        end else begin
          e = q.pop_front();
          check("rnd_err", 32'(oe), 32'(e.err));
          check("rnd_op", 32'(oi[6:0]), 32'(e.op));
          if (!e.err && e.src != 3'b000 && e.src != 3'b111)
            check("rnd_roundtrip", dec_imm(e.src, oi), e.imm);
        end
      end
      if (iv && ir) begin
        if (cur.err) nerr++;
        if (!(sel == 1 && cur.err)) q.push_back(cur);
        sent++;
        have = 1'b0;
      end
      @(negedge clk);
    end
    if (sel == 0) begin in_valid0 = 1'b0; out_ready0 = 1'b1; end
    else begin in_valid1 = 1'b0; out_ready1 = 1'b1; end
    check("rnd_sent", 32'(sent), 32'(n));
    check("rnd_pending", 32'(q.size()), 32'd0);
    // Let trailing dropped entries retire; nothing further may be emitted.
    for (int c = 0; c < 4; c++) begin
      #1;
      ov = (sel == 0) ? out_valid0 : out_valid1;
      check("rnd_tail_quiet", 32'(ov), 32'd0);
      @(negedge clk);
    end
    cnt = (sel == 0) ? 32'(cnt0) : 32'(cnt1);
    check($sformatf("rnd_cnt%0d", sel), cnt, 32'((nerr > cmax) ? cmax : nerr));
  endtask

  initial begin
    int acc;
    int got;
    int seen;
    int nexp;
    logic [31:0] held;

    tbl[0]  = mk(IMM_I,  32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0093, 1'b0);
    tbl[1]  = mk(IMM_B,  32'h0000_0008, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0463, 1'b0);
    tbl[2]  = mk(IMM_B,  32'h0000_0003, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0163, 1'b1);
    tbl[3]  = mk(IMM_J,  32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_00EF, 1'b0);
    tbl[4]  = mk(IMM_U,  32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_52B7, 1'b0);
    tbl[5]  = mk(IMM_S,  32'hFFFF_FFFC, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFE51_2E23, 1'b0);
    tbl[6]  = mk(IMM_SH, 32'h0000_0007, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'h4072_5193, 1'b0);
    tbl[7]  = mk(IMM_R,  32'hDEAD_BEEF, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h0031_00B3, 1'b0);
    tbl[8]  = mk(IMM_I,  32'h0000_07FF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h7FF0_0093, 1'b0);
    tbl[9]  = mk(IMM_I,  32'h0000_0800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0093, 1'b1);
    tbl[10] = mk(IMM_U,  32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_52B7, 1'b1);
    tbl[11] = mk(IMM_SH, 32'h0000_0020, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'h4002_5193, 1'b1);
    tbl[12] = mk(IMM_J,  32'h0000_0801, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_00EF, 1'b1);
    tbl[13] = mk(IMM_J,  32'hFFF0_0000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_00EF, 1'b0);
    tbl[14] = mk(IMM_I,  32'hFFFF_F800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0093, 1'b0);
    tbl[15] = mk(IMM_B,  32'h0000_0FFE, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h7E00_0FE3, 1'b0);
    tbl[16] = mk(IMM_B,  32'h0000_1000, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0063, 1'b1);
    bp[0]   = mk(IMM_I,  32'h0000_0005, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0050_0093, 1'b0);
    bp[1]   = mk(IMM_I,  32'h0000_0005, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0050_0113, 1'b0);
    bp[2]   = mk(IMM_I,  32'h0000_0005, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0050_0193, 1'b0);

    drive_vec(tbl[0]);
    @(negedge clk);
    do_reset();
    #1;
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_instr", instr0, 32'd0);
    check("rst_out_err", 32'(out_err0), 32'd0);
    check("rst_err_count", 32'(cnt0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    check("rst_in_ready_drop", 32'(in_ready1), 32'd1);
    @(negedge clk);

    // One request at a time: 2-cycle latency, exact word and error flag.
    nexp = 0;
    for (int i = 0; i < 17; i++) begin
      drive_vec(tbl[i]);
      in_valid0 = 1'b1; out_ready0 = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready0), 32'd1);
      @(negedge clk);
      in_valid0 = 1'b0;
      #1;
      check($sformatf("v%0d_lat1", i), 32'(out_valid0), 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_lat2", i), 32'(out_valid0), 32'd1);
      check($sformatf("v%0d_instr", i), instr0, tbl[i].exp_instr);
      check($sformatf("v%0d_err", i), 32'(out_err0), 32'(tbl[i].exp_err));
      if (tbl[i].exp_err) nexp++;
      if (i == 2) check("beq3_err_count", 32'(cnt0), 32'd1);
      @(negedge clk);
    end
    check("table_err_count", 32'(cnt0), 32'(nexp));

    // Back-to-back stream: one word per cycle, no bubbles.
    out_ready0 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive_vec(tbl[c]);
      in_valid0 = (c < 3);
      #1;
      if (c < 3) check($sformatf("tp%0d_in_ready", c), 32'(in_ready0), 32'd1);
      if (c >= 2) begin
        check($sformatf("tp%0d_valid", c), 32'(out_valid0), 32'd1);
        check($sformatf("tp%0d_instr", c), instr0, tbl[c-2].exp_instr);
      end
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    @(negedge clk);

    // Backpressure: only two requests fit while the output is stalled.
    out_ready0 = 1'b0; acc = 0; seen = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      if (acc < 3) drive_vec(bp[acc]);
      in_valid0 = (acc < 3);
      #1;
      if (out_valid0) begin
        if (seen == 0) begin held = instr0; seen = 1; end
        else check("bp_hold", instr0, held);
      end
      if (in_valid0 && in_ready0) acc++;
      @(negedge clk);
    end
    #1;
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready0), 32'd0);
    check("bp_held_word", held, bp[0].exp_instr);
    out_ready0 = 1'b1; got = 0;
    for (int c = 0; c < 15; c++) begin
      if (got == 3) break;
      if (acc < 3) drive_vec(bp[acc]);
      in_valid0 = (acc < 3);
      #1;
      if (out_valid0) begin
        if (got < 3) check($sformatf("bp_out%0d", got), instr0, bp[got].exp_instr);
        got++;
      end
      if (in_valid0 && in_ready0) acc++;
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    check("bp_count", 32'(got), 32'd3);
    #1;
    check("bp_no_dup", 32'(out_valid0), 32'd0);
    @(negedge clk);

    // Reset with both stages full and a transfer offered.
    out_ready0 = 1'b0;
    drive_vec(tbl[9]); in_valid0 = 1'b1;
    @(negedge clk);
    drive_vec(tbl[0]);
    @(negedge clk);
    drive_vec(tbl[1]);
    #1;
    check("mr_full", 32'(out_valid0 && !in_ready0), 32'd1);
    check("mr_cnt_nonzero", 32'(cnt0 != 8'd0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid0 = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid0), 32'd0);
    check("mr_err_count", 32'(cnt0), 32'd0);
    check("mr_in_ready", 32'(in_ready0), 32'd1);
    check("mr_instr", instr0, 32'd0);
    out_ready0 = 1'b1; seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (out_valid0) seen++;
    end
    check("mr_no_stale", 32'(seen), 32'd0);
    @(negedge clk);

    do_reset();
    run_random(0, 5000);
    do_reset();
    run_random(1, 5000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Streaming instruction encoder: the inverse of the decode-stage sign-extend unit.
- Accepts an instruction-format selector (ImmSrc), a 32-bit immediate and register/function fields, and packs them into a 32-bit RV32I instruction word.
- Range-checks the immediate and emits results through a 2-stage valid/ready pipeline.
- Sits between the program loader/self-test generator and instruction-memory write port.

Parameters:
- DROP_ON_ERR, 0, 1 = instructions failing the range check are counted but not emitted; 0 = emitted with out_err=1.
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept request
- ImmSrc  input  3  format: 010 J, 001 U, 011 B, 100 S, 101 I, 110 I-shift, other R (no immediate)
- Immediate_value  input  32  immediate as the decoder would produce it (sign-extended / shifted)
- opcode  input  7  instruction[6:0]
- rd  input  5
- rs1  input  5
- rs2  input  5
- funct3  input  3
- funct7  input  7  used by R and I-shift
- out_valid  output  1
- out_ready  input  1
- Instruction  output  32  packed word
- out_err  output  1  immediate not representable in the selected format
- err_count  output  ERR_CNT_W  saturating count of failed requests

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. All valids cleared; Instruction=0, out_err=0, err_count=0, in_ready=1 in the cycle after reset. A transfer in flight during reset is discarded.
- Handshake: a transfer occurs when valid&&ready on a clk edge. Outputs hold stable while out_valid&&!out_ready.
- Stage 1 (S1) registers the inputs and computes the range check. Stage 2 (S2) registers the packed word and error flag.
- Latency: 2 cycles from input accept to out_valid. Throughput is 1/cycle when out_ready=1.
- in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready || (DROP_ON_ERR && s1_err). No combinational path from in_valid to in_ready.
- Range check (err=1 if violated):
  - I, S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - I-shift: imm[31:5]=0.
  - R: never errors.
- Packing (fields in instruction bit order):
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - I-shift: funct7, imm[4:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - R: funct7, rs2, rs1, funct3, rd, opcode.
- On error, the word is packed from truncated bits as above.
- Round-trip invariant: for any err=0 output, decoding Instruction with the same ImmSrc returns Immediate_value exactly.
- err_count increments by 1 when an erroneous entry leaves S1 (emitted or dropped) and saturates at all-ones. It does not increment while stalled.
- DROP_ON_ERR=1: an erroneous S1 entry is discarded without occupying S2; out_err is then constantly 0.
- Simultaneous accept and output-drain in the same cycle is allowed; no bubble is inserted.

Decomposition:
- Shared package:
  - ImmSrc encodings (IMM_J=3'b010, IMM_U=3'b001, IMM_B=3'b011, IMM_S=3'b100, IMM_I=3'b101, IMM_SH=3'b110)
  - RV32I opcode constants
- Sub-module imm_pack_check: purely combinational packer plus range check, instantiated in S1→S2. It is reusable by the bench as a reference.
- Top: pipeline registers, handshake, counter.

Test Plan:
- addi x1,x0,-1: ImmSrc=101, imm=0xFFFFFFFF, opcode=0x13, rd=1, rs1=0, funct3=0 → Instruction=0xFFF00093, out_err=0, out_valid exactly 2 cycles after accept.
- beq x0,x0,+8: ImmSrc=011, imm=0x00000008, opcode=0x63 → 0x00000463. Same with imm=3 → out_err=1, err_count=1.
- jal x1,+2048: ImmSrc=010, imm=0x00000800, rd=1, opcode=0x6F → 0x001000EF. lui x5,0x12345: ImmSrc=001, imm=0x12345000 → 0x123452B7.
- Backpressure: out_ready=0 for 5 cycles while 3 requests are offered → exactly 2 accepted, in_ready=0. Outputs stay stable. On release, the 3 words emerge in order with no loss or duplication.
- Reset mid-stream with both stages full → next cycle out_valid=0, err_count=0, in_ready=1. No stale word is emitted.
- Random 10k requests at random out_ready: decoding each err=0 Instruction matches Immediate_value; err_count matches the reference count (saturation tested with ERR_CNT_W=2). Run with DROP_ON_ERR=1 → no erroneous word ever emitted.
